// File: rtl/uart_motor_cmd_parser.sv
// uart_motor_cmd_parser
//   Frame parser between rx_module and the two pwm_module instances. Collects
//   4-byte frames (HEADER, CMD, DUTY, CHK) from the UART receiver and validates
//   them. It latches per-motor direction/duty, pulses Start_En_Sig, and tracks
//   each motor's busy state from its Done_Sig. It also drives rx_module's
//   receive enable.
//
//   Frame check:
//     CMD[7:6] selects the motor(s): 01 M1, 10 M2, 11 both; 00 is rejected.
//     CMD[5:2] must be zero. CMD[1:0] is the direction.
//     CHK must equal CMD ^ DUTY.
//
//   Optional feature macro: FRAME_TIMEOUT_EN
//     When defined, the parameter TIMEOUT_CYCLES exists and a frame is
//     abandoned if no byte arrives within TIMEOUT_CYCLES clocks while the
//     parser is in CMD/DUTY/CHK. When undefined, the parser waits
//     indefinitely for the next byte.
//
// Ports
//   clk                in   system clock
//   reset              in   asynchronous, active-high reset
//   rx_data[7:0]       in   received byte, valid with rx_done
//   rx_done            in   one-cycle byte-received strobe
//   rx_en              out  receive enable to rx_module
//   m1_done/m2_done    in   pwm_module Done_Sig pulses
//   m1_start/m2_start  out  pwm_module Start_En_Sig pulses
//   m1_dir/m2_dir      out  mode: 00 coast, 01 fwd, 10 rev, 11 brake
//   m1_duty/m2_duty    out  duty 0..255
//   frame_ok           out  pulse: frame accepted and issued
//   frame_err          out  pulse: frame rejected
//   err_cnt[ERR_W-1:0] out  saturating rejected-frame count
module uart_motor_cmd_parser #(
  parameter logic [7:0]  HEADER         = 8'hA5,
`ifdef FRAME_TIMEOUT_EN
  parameter int unsigned TIMEOUT_CYCLES = 491520,
`endif
  parameter int unsigned ERR_W          = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       rx_data,
  input  logic             rx_done,
  output logic             rx_en,
  input  logic             m1_done,
  input  logic             m2_done,
  output logic             m1_start,
  output logic             m2_start,
  output logic [1:0]       m1_dir,
  output logic [1:0]       m2_dir,
  output logic [7:0]       m1_duty,
  output logic [7:0]       m2_duty,
  output logic             frame_ok,
  output logic             frame_err,
  output logic [ERR_W-1:0] err_cnt
);

  typedef enum logic [2:0] {
    S_HUNT,
    S_CMD,
    S_DUTY,
    S_CHK,
    S_ISSUE
  } state_t;

  localparam logic [ERR_W-1:0] ERR_ONE = ERR_W'(1);

  state_t           state_q;
  logic [7:0]       cmd_q;
  logic [7:0]       duty_q;
  logic             m1_busy_q;
  logic             m2_busy_q;
  logic             rx_en_q;
  logic             m1_start_q;
  logic             m2_start_q;
  logic [1:0]       m1_dir_q;
  logic [1:0]       m2_dir_q;
  logic [7:0]       m1_duty_q;
  logic [7:0]       m2_duty_q;
  logic             frame_ok_q;
  logic             frame_err_q;
  logic [ERR_W-1:0] err_cnt_q;
  logic [ERR_W-1:0] err_cnt_d;

  logic sel1;
  logic sel2;
  logic frame_good;
  logic issue_go;
  logic enter_issue;
  logic tmo_hit;

  always_comb begin
    sel1       = cmd_q[6];
    sel2       = cmd_q[7];
    // Evaluated while the CHK byte is on rx_data.
    frame_good = (cmd_q[7:6] != 2'b00) && (cmd_q[5:2] == 4'b0000) &&
                 (rx_data == (cmd_q ^ duty_q));
    issue_go   = (state_q == S_ISSUE) &&
                 !(sel1 && m1_busy_q) && !(sel2 && m2_busy_q);
    // rx_en is registered, so it is computed from where the FSM will be
    // next cycle. This keeps it low for the whole time spent in ISSUE.
    enter_issue = ((state_q == S_CHK) && rx_done && frame_good) ||
                  ((state_q == S_ISSUE) && !issue_go);
    err_cnt_d  = (err_cnt_q == '1) ? err_cnt_q : err_cnt_q + ERR_ONE;
  end

`ifdef FRAME_TIMEOUT_EN
  localparam int unsigned     TW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0]   TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0]   TMO_ONE  = TW'(1);

  logic [TW-1:0] tmo_q;
  logic          in_frame;

  always_comb begin
    in_frame = (state_q == S_CMD) || (state_q == S_DUTY) || (state_q == S_CHK);
    tmo_hit  = in_frame && !rx_done && (tmo_q == TMO_LAST);
  end

  // Counts idle cycles since the last received byte, only mid-frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tmo_q <= '0;
    end else if (rx_done || !in_frame || tmo_hit) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_q + TMO_ONE;
    end
  end
`else
  always_comb tmo_hit = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_HUNT;
      cmd_q       <= '0;
      duty_q      <= '0;
      m1_busy_q   <= 1'b0;
      m2_busy_q   <= 1'b0;
      rx_en_q     <= 1'b0;
      m1_start_q  <= 1'b0;
      m2_start_q  <= 1'b0;
      m1_dir_q    <= '0;
      m2_dir_q    <= '0;
      m1_duty_q   <= '0;
      m2_duty_q   <= '0;
      frame_ok_q  <= 1'b0;
      frame_err_q <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      m1_start_q  <= 1'b0;
      m2_start_q  <= 1'b0;
      frame_ok_q  <= 1'b0;
      frame_err_q <= 1'b0;
      rx_en_q     <= !rx_done && !enter_issue;

      // A done pulse clears busy; an issue in the same cycle, assigned
      // later below, takes precedence and keeps busy set.
      if (m1_done) m1_busy_q <= 1'b0;
      if (m2_done) m2_busy_q <= 1'b0;

      if (tmo_hit) begin
        frame_err_q <= 1'b1;
        err_cnt_q   <= err_cnt_d;
        state_q     <= S_HUNT;
      end else begin
        case (state_q)
          S_HUNT: begin
            if (rx_done && (rx_data == HEADER)) state_q <= S_CMD;
          end
          S_CMD: begin
            if (rx_done) begin
              cmd_q   <= rx_data;
              state_q <= S_DUTY;
            end
          end
          S_DUTY: begin
            if (rx_done) begin
              duty_q  <= rx_data;
              state_q <= S_CHK;
            end
          end
          S_CHK: begin
            if (rx_done) begin
              if (frame_good) begin
                state_q <= S_ISSUE;
              end else begin
                frame_err_q <= 1'b1;
                err_cnt_q   <= err_cnt_d;
                state_q     <= S_HUNT;
              end
            end
          end
          S_ISSUE: begin
            // Bytes arriving here are dropped silently.
            if (issue_go) begin
              if (sel1) begin
                m1_dir_q   <= cmd_q[1:0];
                m1_duty_q  <= duty_q;
                m1_start_q <= 1'b1;
                m1_busy_q  <= 1'b1;
              end
              if (sel2) begin
                m2_dir_q   <= cmd_q[1:0];
                m2_duty_q  <= duty_q;
                m2_start_q <= 1'b1;
                m2_busy_q  <= 1'b1;
              end
              frame_ok_q <= 1'b1;
              state_q    <= S_HUNT;
            end
          end
          default: state_q <= S_HUNT;
        endcase
      end
    end
  end

  assign rx_en     = rx_en_q;
  assign m1_start  = m1_start_q;
  assign m2_start  = m2_start_q;
  assign m1_dir    = m1_dir_q;
  assign m2_dir    = m2_dir_q;
  assign m1_duty   = m1_duty_q;
  assign m2_duty   = m2_duty_q;
  assign frame_ok  = frame_ok_q;
  assign frame_err = frame_err_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_uart_motor_cmd_parser.sv
// Self-checking bench for uart_motor_cmd_parser: directed scenarios plus
// randomized frames checked against a frame-level reference model.
module tb_uart_motor_cmd_parser;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic       rx_done = 1'b0;
  logic       m1_done = 1'b0;
  logic       m2_done = 1'b0;
  logic       rx_en;
  logic       m1_start, m2_start;
  logic [1:0] m1_dir, m2_dir;
  logic [7:0] m1_duty, m2_duty;
  logic       frame_ok, frame_err;
  logic [7:0] err_cnt;

  uart_motor_cmd_parser #(
`ifdef FRAME_TIMEOUT_EN
    .TIMEOUT_CYCLES(40),
`endif
    .HEADER(8'hA5),
    .ERR_W(8)
  ) dut (
    .clk(clk), .reset(reset),
    .rx_data(rx_data), .rx_done(rx_done), .rx_en(rx_en),
    .m1_done(m1_done), .m2_done(m2_done),
    .m1_start(m1_start), .m2_start(m2_start),
    .m1_dir(m1_dir), .m2_dir(m2_dir),
    .m1_duty(m1_duty), .m2_duty(m2_duty),
    .frame_ok(frame_ok), .frame_err(frame_err),
    .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Pulse counters observed on the falling edge.
  int n_m1 = 0, n_m2 = 0, n_ok = 0, n_err = 0;
  always @(negedge clk) begin
    if (m1_start === 1'b1)  n_m1++;
    if (m2_start === 1'b1)  n_m2++;
    if (frame_ok === 1'b1)  n_ok++;
    if (frame_err === 1'b1) n_err++;
  end

  // Reference model state.
  logic [1:0] e_m1_dir, e_m2_dir;
  logic [7:0] e_m1_duty, e_m2_duty, e_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    e_m1_dir = 2'b00; e_m2_dir = 2'b00;
    e_m1_duty = 8'h00; e_m2_duty = 8'h00;
    e_err = 8'h00;
  endtask

  task automatic model_frame(input logic [7:0] cmd, input logic [7:0] duty,
                             input logic [7:0] c,
                             output int s1, output int s2, output int ok, output int er);
    bit good;
    good = (cmd[7:6] != 2'b00) && (cmd[5:2] == 4'b0000) && (c == (cmd ^ duty));
    s1 = 0; s2 = 0; ok = 0; er = 0;
    if (good) begin
      ok = 1;
      if (cmd[6]) begin s1 = 1; e_m1_dir = cmd[1:0]; e_m1_duty = duty; end
      if (cmd[7]) begin s2 = 1; e_m2_dir = cmd[1:0]; e_m2_duty = duty; end
    end else begin
      er = 1;
      if (e_err != 8'hFF) e_err = e_err + 8'h01;
    end
  endtask

  // Called on a falling edge; returns on the falling edge after the strobe.
  task automatic send_byte(input logic [7:0] b);
    int w;
    w = 0;
    while (rx_en !== 1'b1 && w < 1000) begin
      @(negedge clk);
      w++;
    end
    if (rx_en !== 1'b1) chk("rx_en_wait", rx_en, 1);
    rx_data = b;
    rx_done = 1'b1;
    @(negedge clk);
    rx_done = 1'b0;
  endtask

  task automatic done_pulse();
    m1_done = 1'b1;
    m2_done = 1'b1;
    @(negedge clk);
    m1_done = 1'b0;
    m2_done = 1'b0;
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, "_m1dir"},  m1_dir,  e_m1_dir);
    chk({tag, "_m1duty"}, m1_duty, e_m1_duty);
    chk({tag, "_m2dir"},  m2_dir,  e_m2_dir);
    chk({tag, "_m2duty"}, m2_duty, e_m2_duty);
    chk({tag, "_errcnt"}, err_cnt, e_err);
  endtask

  task automatic run_frame(input logic [7:0] cmd, input logic [7:0] duty,
                           input logic [7:0] c, input bit do_done, input string tag);
    int b1, b2, bo, be, s1, s2, ok, er;
    b1 = n_m1; b2 = n_m2; bo = n_ok; be = n_err;
    send_byte(8'hA5);
    send_byte(cmd);
    send_byte(duty);
    send_byte(c);
    repeat (3) @(negedge clk);
    model_frame(cmd, duty, c, s1, s2, ok, er);
    chk({tag, "_m1start"}, n_m1 - b1, s1);
    chk({tag, "_m2start"}, n_m2 - b2, s2);
    chk({tag, "_ok"},      n_ok - bo, ok);
    chk({tag, "_err"},     n_err - be, er);
    check_outputs(tag);
    if (do_done) done_pulse();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rst_rx_en", rx_en, 0);
    chk("rst_pulses", {m1_start, m2_start, frame_ok, frame_err}, 0);
    chk("rst_outs", {m1_dir, m2_dir, m1_duty, m2_duty, err_cnt}, 0);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_rx_en_after", rx_en, 1);
    model_reset();
  endtask

  initial begin
    int b1, b2, bo, be, nj;
    logic [7:0] cmd, duty, c, jb;
    logic [1:0] sel, dir;

    model_reset();
    @(negedge clk);
    do_reset();

    // Latency: A5 41 80 C1 -> start two cycles after the CHK strobe.
    send_byte(8'hA5);
    send_byte(8'h41);
    send_byte(8'h80);
    @(negedge clk);
    rx_data = 8'hC1;
    rx_done = 1'b1;
    @(negedge clk);
    rx_done = 1'b0;
    chk("lat_rx_en_low", rx_en, 0);
    chk("lat_early", m1_start, 0);
    @(negedge clk);
    chk("lat_m1start", m1_start, 1);
    chk("lat_m2start", m2_start, 0);
    chk("lat_ok", frame_ok, 1);
    chk("lat_dir", m1_dir, 2'b01);
    chk("lat_duty", m1_duty, 8'h80);
    e_m1_dir = 2'b01; e_m1_duty = 8'h80;
    @(negedge clk);
    chk("lat_pulse_width", {m1_start, frame_ok}, 0);
    chk("lat_rx_en_back", rx_en, 1);

    // M1 still busy (no done yet): second M1 frame waits for m1_done.
    b1 = n_m1;
    send_byte(8'hA5);
    send_byte(8'h41);
    send_byte(8'h33);
    send_byte(8'h72);
    repeat (6) @(negedge clk);
    chk("busy_no_start", n_m1 - b1, 0);
    chk("busy_rx_en", rx_en, 0);
    m1_done = 1'b1;
    @(negedge clk);
    m1_done = 1'b0;
    chk("busy_not_yet", m1_start, 0);
    @(negedge clk);
    chk("busy_start", m1_start, 1);
    chk("busy_duty", m1_duty, 8'h33);
    e_m1_dir = 2'b01; e_m1_duty = 8'h33;
    @(negedge clk);
    done_pulse();

    run_frame(8'hC2, 8'h40, 8'h82, 1'b1, "both");
    run_frame(8'h41, 8'h80, 8'hC0, 1'b1, "badchk");
    run_frame(8'h00, 8'h11, 8'h11, 1'b1, "sel00");
    run_frame(8'h45, 8'h11, 8'h54, 1'b1, "cmdbits");

    // Junk before the header is skipped silently.
    be = n_err;
    send_byte(8'h00);
    send_byte(8'h12);
    run_frame(8'h41, 8'h10, 8'h51, 1'b1, "junk");
    chk("junk_no_err", n_err - be, 0);

    // Reset while waiting for DUTY: frame discarded.
    b1 = n_m1; bo = n_ok; be = n_err;
    send_byte(8'hA5);
    send_byte(8'h41);
    do_reset();
    send_byte(8'h80);
    send_byte(8'hC1);
    repeat (3) @(negedge clk);
    chk("rstduty_start", n_m1 - b1, 0);
    chk("rstduty_okerr", (n_ok - bo) + (n_err - be), 0);
    check_outputs("rstduty");

    // Reset while stalled in ISSUE: no start, busy cleared.
    run_frame(8'h41, 8'h20, 8'h61, 1'b0, "pre_issue");
    b1 = n_m1;
    send_byte(8'hA5);
    send_byte(8'h41);
    send_byte(8'h30);
    send_byte(8'h71);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("rstissue_start", n_m1 - b1, 0);
    reset = 1'b0;
    model_reset();
    @(negedge clk);
    run_frame(8'h41, 8'h55, 8'h14, 1'b1, "post_reset");

`ifdef FRAME_TIMEOUT_EN
    be = n_err;
    send_byte(8'hA5);
    send_byte(8'h41);
    repeat (60) @(negedge clk);
    chk("tmo_err", n_err - be, 1);
    if (e_err != 8'hFF) e_err = e_err + 8'h01;
    chk("tmo_errcnt", err_cnt, e_err);
    run_frame(8'h41, 8'h66, 8'h27, 1'b1, "tmo_after");
`endif

    // Randomized frames against the reference model.
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 9) < 7) begin
        sel = 2'($urandom_range(1, 3));
        dir = 2'($urandom_range(0, 3));
        cmd = {sel, 4'b0000, dir};
      end else begin
        cmd = 8'($urandom);
      end
      duty = 8'($urandom);
      c = cmd ^ duty;
      if ($urandom_range(0, 3) == 0) c = c ^ 8'($urandom_range(1, 255));
      nj = $urandom_range(0, 2);
      for (int j = 0; j < nj; j++) begin
        jb = 8'($urandom);
        if (jb == 8'hA5) jb = 8'h00;
        send_byte(jb);
      end
      run_frame(cmd, duty, c, 1'b1, "rand");
    end

    // Error counter saturation.
    for (int k = 0; k < 260; k++) begin
      send_byte(8'hA5);
      send_byte(8'h41);
      send_byte(8'h80);
      send_byte(8'hC0);
      if (e_err != 8'hFF) e_err = e_err + 8'h01;
    end
    repeat (3) @(negedge clk);
    chk("sat_errcnt", err_cnt, 8'hFF);
    run_frame(8'h41, 8'h80, 8'hC0, 1'b1, "sat_hold");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Absolute time bound.
  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, observed running expected done");
    $fatal(1, "timeout");
  end

endmodule
